down_counter_timer: RTL and testbench
=====================================

# down_counter_timer

Loadable down-counting timer, the decrementing counterpart to the free-running up counter in the counter library. Software or a controlling FSM loads a start value, starts the countdown, and may pause/resume it. The block signals expiry with a one-cycle `done` pulse. An internal prescaler sets the decrement rate, so the same block serves as a cycle counter or a coarse timeout generator.

## Interface
- `COUNT_WIDTH`, default 4: width of count and load value. Range 0..2^COUNT_WIDTH-1.
- `PRESCALE`, default 1: clk cycles per decrement, ≥1. 1 means decrement every cycle.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load` in 1: load `load_val` into count and reload register.
- `load_val` in COUNT_WIDTH: value captured on `load`.
- `start` in 1: begin or resume the countdown.
- `stop` in 1: pause the countdown.
- `count_out` out COUNT_WIDTH: current count, registered.
- `busy` out 1: high in RUN or PAUSE.
- `paused` out 1: high in PAUSE.
- `done` out 1: one-cycle expiry pulse, registered.

## Operation
- States:
  - IDLE: loaded, not started.
  - RUN: counting.
  - PAUSE: count held.
  - DONE: expired, count = 0.
- Command priority per edge: `load` > `stop` > `start`.
- `load`, any state:
  - count and reload_reg ← `load_val`; state → IDLE; prescaler cleared.
  - `done` is not asserted on a load edge.
- `start`:
  - In IDLE with count ≠ 0: → RUN.
  - In IDLE with count = 0: ignored.
  - In PAUSE: → RUN.
  - In RUN or DONE: ignored.
- `stop` in RUN: → PAUSE; count held; prescaler cleared. Ignored in other states.
- `stop` and `start` on the same edge in RUN or PAUSE: stop wins, state is PAUSE.
- Decrement:
  - Only in RUN, on a prescaler tick; count ← count − 1.
  - The tick edge where count goes 1→0: state → DONE, `done` = 1 for exactly that following cycle.
- DONE: holds count 0. Only `load` or `rst` leaves it.
- Arithmetic: unsigned, COUNT_WIDTH bits. Count never decrements below 0; no underflow wrap.
- `busy` = (state == RUN || state == PAUSE). `paused` = (state == PAUSE). Both are registered/decoded from the state register, with no input-to-output combinational path.

## Timing
- Reset values:
  - count_out = 0, reload_reg = 0, state = IDLE.
  - busy = 0, paused = 0, done = 0, prescaler = 0.
- Reset mid-count clears everything asynchronously. No `done` pulse is produced.
- `start` accepted at edge k:
  - Decrements occur at edges k+P, k+2P, …, where P = PRESCALE.
  - count_out reaches 0 and `done` rises at edge k + N·P, where N = loaded value.
- The prescaler counts only in RUN. PAUSE freezes progress: resuming after a pause costs the full P cycles to the next decrement (prescaler was cleared).
- `load` during RUN aborts the countdown. The new value is visible at the next edge, state is IDLE, and no `done` is produced.

## Configuration
- Macro: `DOWN_COUNTER_TIMER_AUTO_RELOAD_EN`.
- Defined:
  - On the 1→0 tick, count ← reload_reg, `done` pulses one cycle, and state stays RUN. Periodic operation, period N·P cycles.
  - DONE is unreachable except when reload_reg = 0.
  - `stop`/`start`/`load` behave as above.
- Undefined: one-shot behaviour as described in Operation.

## Structure
- Package `counter_pkg`:
  - `typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} timer_state_t`.
  - Shared localparam helpers for prescaler width: `$clog2(PRESCALE)` with a minimum of 1 bit.
- Sub-module `counter_prescaler`:
  - Parameter PRESCALE; inputs clk, rst, `en` (RUN), `clr`; output `tick`.
  - `tick` is a one-cycle pulse every PRESCALE enabled cycles.
  - When PRESCALE = 1, `tick` = `en`.
- Top module holds the FSM, count and reload registers, and the `done` register.

## Test plan
- Reset/basic (WIDTH=4, P=1): load 5, start at edge k → count_out 4,3,2,1,0 at k+1..k+5; `done` high only at k+5; busy falls at k+5.
- Prescaler (P=3): load 2, start → decrements at k+3 and k+6; `done` at k+6; count stable between ticks.
- Pause/resume (P=1): load 8, start, stop after 3 decrements → count holds 5, paused=1 for 10 cycles. Start again → reaches 0 five cycles later, one `done` pulse.
- Priorities: load 9 with start+stop asserted → IDLE, count 9. Stop+start together in RUN → PAUSE. Start with count 0 → stays IDLE, busy 0.
- Abort/reset: load 6, start, assert `rst` asynchronously mid-cycle at count 3 → all outputs 0 immediately, no `done`. Separately, `load` 4 during RUN → IDLE, count 4, no `done`.
- Auto-reload (macro defined, P=1): load 3, start → count 2,1,3,2,1,3…; `done` every 3 cycles; busy stays 1. Stop → pause holds value.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter library.
// The state encoding is used by down_counter_timer.
// prescale_width sizes prescaler phase registers.
package counter_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} timer_state_t;

  // Phase register width for a divide-by-p prescaler: $clog2(p), at least 1 bit
  function automatic int prescale_width(input int p);
    return (p <= 1) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Rate divider: emits a one-cycle tick once every PRESCALE enabled cycles.
// With PRESCALE = 1 the phase register never leaves 0, so tick = en.
// clr restarts the phase so that the next tick is a full period away.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  // Phase counter advances only while enabled and wraps after LAST
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + PW'(1);
    end
  end

  assign tick = en && (phase == LAST);

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with pause/resume and a one-cycle done pulse.
// Optional macro DOWN_COUNTER_TIMER_AUTO_RELOAD_EN: on expiry, reload the
// count from the reload register and keep running (periodic mode).
// Command priority on each edge is load > stop > start.
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int COUNT_WIDTH = 4,
  parameter int PRESCALE    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_val,
  input  logic                   start,
  input  logic                   stop,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   busy,
  output logic                   paused,
  output logic                   done
);

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  timer_state_t           state;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] reload;
  logic                   done_pulse;
  logic                   tick;

  // The prescaler only runs in RUN; load and stop restart its phase
  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (state == ST_RUN),
    .clr (load || stop),
    .tick(tick)
  );

  // Timer FSM with count, reload and done registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload     <= '0;
      done_pulse <= 1'b0;
    end else if (load) begin
      state      <= ST_IDLE;
      count      <= load_val;
      reload     <= load_val;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          // stop outranks start even though it has no effect here
          if (!stop && start && (count != '0)) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_PAUSE;
          end else if (tick) begin
            if (count == ONE) begin
              done_pulse <= 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
              if (reload != '0) begin
                count <= reload;
              end else begin
                count <= '0;
                state <= ST_DONE;
              end
`else
              count <= '0;
              state <= ST_DONE;
`endif
            end else if (count != '0) begin
              count <= count - ONE;
            end
          end
        end
        ST_PAUSE: begin
          if (!stop && start) begin
            state <= ST_RUN;
          end
        end
        ST_DONE: begin
          // Held at zero until load or reset
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign count_out = count;
  assign done      = done_pulse;
  assign busy      = (state == ST_RUN) || (state == ST_PAUSE);
  assign paused    = (state == ST_PAUSE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Testbench for down_counter_timer: two instances (PRESCALE 1 and 3) share
// the same stimulus. A table of vectors, hand-written corner sequences and
// a random phase are checked against a behavioural model.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;

  logic [3:0] count1, count3;
  logic       busy1, paused1, done1;
  logic       busy3, paused3, done3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  down_counter_timer #(.COUNT_WIDTH(4), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .stop(stop),
    .count_out(count1), .busy(busy1), .paused(paused1), .done(done1)
  );

  down_counter_timer #(.COUNT_WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .stop(stop),
    .count_out(count3), .busy(busy3), .paused(paused3), .done(done3)
  );

  // Behavioural model: mode 0 idle, 1 running, 2 paused, 3 expired.
  // elapsed = running cycles since the last decrement / start.
  typedef struct {
    int mode;
    int cnt;
    int rel;
    int elapsed;
    bit dn;
  } mdl_t;

  mdl_t m1, m3;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = 0; r.cnt = 0; r.rel = 0; r.elapsed = 0; r.dn = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int p, bit l, int lv, bit st, bit sp);
    mdl_t r = m;
    r.dn = 0;
    if (l) begin
      r.cnt = lv; r.rel = lv; r.mode = 0; r.elapsed = 0;
      return r;
    end
    if (sp) begin
      if (m.mode == 1) begin
        r.mode = 2; r.elapsed = 0;
      end
      return r;
    end
    if (st && ((m.mode == 0 && m.cnt != 0) || m.mode == 2)) begin
      r.mode = 1;
      return r;
    end
    if (m.mode == 1) begin
      r.elapsed = m.elapsed + 1;
      if (r.elapsed == p) begin
        r.elapsed = 0;
        r.cnt = m.cnt - 1;
        if (r.cnt == 0) begin
          r.dn = 1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
          if (m.rel != 0) r.cnt = m.rel;
          else r.mode = 3;
`else
          r.mode = 3;
`endif
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_models();
    chk("p1_count", int'(count1), m1.cnt);
    chk("p1_busy", int'(busy1), int'(m1.mode == 1 || m1.mode == 2));
    chk("p1_paused", int'(paused1), int'(m1.mode == 2));
    chk("p1_done", int'(done1), int'(m1.dn));
    chk("p3_count", int'(count3), m3.cnt);
    chk("p3_busy", int'(busy3), int'(m3.mode == 1 || m3.mode == 2));
    chk("p3_paused", int'(paused3), int'(m3.mode == 2));
    chk("p3_done", int'(done3), int'(m3.dn));
  endtask

  // Drive one edge's commands (called at negedge), update models, check at next negedge
  task automatic step(input bit l, input int lv, input bit st, input bit sp);
    load = l; load_val = 4'(lv); start = st; stop = sp;
    @(posedge clk);
    m1 = mdl_next(m1, 1, l, lv, st, sp);
    m3 = mdl_next(m3, 3, l, lv, st, sp);
    @(negedge clk);
    chk_models();
    $display("step load=%0d val=%0d start=%0d stop=%0d | p1 cnt=%0d busy=%0d paused=%0d done=%0d | p3 cnt=%0d done=%0d",
             l, lv, st, sp, count1, busy1, paused1, done1, count3, done3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load = 1'b0; start = 1'b0; stop = 1'b0; load_val = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m1 = mdl_reset();
    m3 = mdl_reset();
    chk_models();
  endtask

  typedef struct {
    bit   l;
    int   lv;
    bit   st;
    bit   sp;
    int   cnt;
    bit   bsy;
    bit   pau;
    bit   dn;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int cyc;
    int dcount;
    int exp3[5];
    bit seen;

    // Directed vectors for the PRESCALE=1 instance (one-shot expectations)
    tbl[0]  = '{1, 5, 0, 0, 5, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 5, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 4, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 3, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 2, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 1, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 9, 1, 1, 9, 0, 0, 0};
    tbl[10] = '{0, 0, 1, 0, 9, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 8, 1, 0, 0};
    tbl[12] = '{0, 0, 1, 1, 8, 1, 1, 0};
    tbl[13] = '{0, 0, 0, 0, 8, 1, 1, 0};
    tbl[14] = '{0, 0, 1, 0, 8, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 7, 1, 0, 0};
    tbl[16] = '{1, 4, 0, 0, 4, 0, 0, 0};
    tbl[17] = '{0, 0, 0, 0, 4, 0, 0, 0};
    tbl[18] = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[19] = '{0, 0, 1, 0, 0, 0, 0, 0};

    @(negedge clk);
    do_reset();
    chk("reset_count", int'(count1), 0);
    chk("reset_busy", int'(busy1), 0);
    chk("reset_paused", int'(paused1), 0);
    chk("reset_done", int'(done1), 0);

`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].l, tbl[i].lv, tbl[i].st, tbl[i].sp);
      chk($sformatf("tbl%0d_count", i), int'(count1), tbl[i].cnt);
      chk($sformatf("tbl%0d_busy", i), int'(busy1), int'(tbl[i].bsy));
      chk($sformatf("tbl%0d_paused", i), int'(paused1), int'(tbl[i].pau));
      chk($sformatf("tbl%0d_done", i), int'(done1), int'(tbl[i].dn));
    end
`endif

    // Prescaler 3: load 2, start at edge k -> decrements at k+3, k+6
    exp3 = '{2, 2, 1, 1, 1};
    step(1, 2, 0, 0);
    step(0, 0, 1, 0);
    chk("ps_after_start", int'(count3), 2);
    cyc = 0;
    seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      step(0, 0, 0, 0);
      if (done3) begin
        seen = 1;
        cyc = i;
      end else if (i <= 5) begin
        chk($sformatf("ps_count_k%0d", i), int'(count3), exp3[i-1]);
      end
    end
    chk("ps_done_latency", cyc, 6);

    // Pause / resume on the PRESCALE=1 instance
    step(1, 8, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      chk("pause_hold_count", int'(count1), 5);
      chk("pause_paused", int'(paused1), 1);
    end
    step(0, 0, 1, 0);
    cyc = 0;
    dcount = 0;
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 0, 0);
      if (done1) begin
        dcount++;
        if (cyc == 0) cyc = i;
      end
    end
    chk("resume_done_latency", cyc, 5);
`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    chk("resume_done_pulses", dcount, 1);
`endif

    // Asynchronous reset mid-count at count 3
    step(1, 6, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("abort_pre_count", int'(count1), 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", int'(count1), 0);
    chk("async_rst_busy", int'(busy1), 0);
    chk("async_rst_done", int'(done1), 0);
    chk("async_rst_count3", int'(count3), 0);
    @(negedge clk);
    rst = 1'b0;
    m1 = mdl_reset();
    m3 = mdl_reset();
    chk_models();
    step(0, 0, 0, 0);

    // Load during RUN aborts without a done pulse
    step(1, 7, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(1, 4, 0, 0);
    chk("load_abort_count", int'(count1), 4);
    chk("load_abort_busy", int'(busy1), 0);
    chk("load_abort_done", int'(done1), 0);

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    // Periodic operation: 2,1,3,2,1,3,... with done on each reload
    step(1, 3, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 0);
      chk("ar_count", int'(count1), 3 - ((i + 1) % 3));
      chk("ar_done", int'(done1), int'((i % 3) == 2));
      chk("ar_busy", int'(busy1), 1);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("ar_pause_paused", int'(paused1), 1);
`endif

    // Randomized commands checked against the model
    for (int i = 0; i < 3000; i++) begin
      bit l, st, sp;
      int lv;
      l  = ($urandom_range(0, 19) == 0);
      lv = $urandom_range(0, 15);
      st = ($urandom_range(0, 3) == 0);
      sp = !st && ($urandom_range(0, 11) == 0);
      step(l, lv, st, sp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
